// File: rtl/sd_seq_gen_pkg.sv
// Shared constants for the sd_seq_gen traffic producer and its LFSR.
// State encodings are plain constants so legacy code can compare against them.
package sd_seq_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic int count_sz(input int width, input int tag_sz);
      return width - tag_sz;
   endfunction

endpackage

// File: rtl/sd_seq_gen_if.sv
// Srdy/drdy producer-to-consumer channel carrying one data word per transfer.
interface sd_seq_gen_if #(parameter int width = 8);

   logic             p_srdy;
   logic             p_drdy;
   logic [width-1:0] p_data;

   modport master (output p_srdy, output p_data, input p_drdy);
   modport slave  (input p_srdy, input p_data, output p_drdy);

endinterface

// File: rtl/sd_lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left while enabled; shared by the env traffic generators.
module sd_lfsr8
   import sd_seq_gen_pkg::*;
#(
   parameter logic [7:0] seed = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] state
);

   always_ff @(posedge clk) begin
      if (reset)
         state <= seed;
      else if (en)
         state <= {state[6:0], ^(state & LFSR_TAPS)};
   end

endmodule

// File: rtl/sd_seq_gen.sv
// Incrementing-sequence srdy/drdy producer with LFSR-throttled offers and a
// programmable run length (0 = unlimited).
module sd_seq_gen
   import sd_seq_gen_pkg::*;
#(
   parameter int               width     = 8,
   parameter int               tag_sz    = 1,
   parameter logic [tag_sz-1:0] tag_val  = '0,
   parameter logic [7:0]       lfsr_seed = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] num_xfers,
   input  logic [2:0]  rate,
   sd_seq_gen_if.master p,
   output logic        busy,
   output logic        done,
   output logic [15:0] xfer_cnt
);

   localparam int CNT_SZ = count_sz(width, tag_sz);

   logic [1:0]        state;
   logic [7:0]        lfsr;
   logic [CNT_SZ-1:0] seq;
   logic [15:0]       limit;
   logic              srdy;
   logic              offer;
   logic              fire;
   logic              last;

   sd_lfsr8 #(.seed(lfsr_seed)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (state == ST_RUN),
      .state (lfsr)
   );

   // Offer when the low three LFSR bits do not exceed rate; rate 7 always offers.
   assign offer = (rate == 3'd7) || ((lfsr & 8'h07) <= {5'b0, rate});
   assign fire  = srdy && p.p_drdy;
   assign last  = (limit != '0) && ((xfer_cnt + 16'd1) == limit);

   assign p.p_srdy = srdy;
   assign p.p_data = {tag_val, seq};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         srdy     <= 1'b0;
         seq      <= '0;
         limit    <= '0;
         xfer_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_RUN;
                  limit    <= num_xfers;
                  xfer_cnt <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  srdy     <= offer;
               end
            end
            ST_RUN: begin
               if (fire) begin
                  seq <= seq + 1'b1;
                  if (xfer_cnt != '1)
                     xfer_cnt <= xfer_cnt + 16'd1;
                  if (last) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     srdy  <= 1'b0;
                  end else begin
                     srdy <= offer;
                  end
               end else if (!srdy) begin
                  // A pending offer is held until accepted; only an idle slot re-decides.
                  srdy <= offer;
               end
            end
            default: begin
               state <= ST_IDLE;
               srdy  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_seq_gen.sv
// Bench for sd_seq_gen (width 8, tag 1): per-cycle reference model, table-driven
// runs, randomized runs and hand-written backpressure/wrap/reset sequences.
module tb_sd_seq_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_xfers = '0;
   logic [2:0]  rate = 3'd7;
   logic        busy;
   logic        done;
   logic [15:0] xfer_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int g = 0;
   logic [7:0] words[$];

   sd_seq_gen_if #(.width(8)) sif ();

   sd_seq_gen #(.width(8), .tag_sz(1), .tag_val(1'b1), .lfsr_seed(8'hA5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_xfers (num_xfers),
      .rate      (rate),
      .p         (sif),
      .busy      (busy),
      .done      (done),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules with integer arithmetic.
   typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
   mmode_t     m_mode = M_IDLE;
   bit         m_valid = 1'b0;
   bit         m_srdy = 1'b0;
   bit         m_fire;
   int         m_seq = 0;
   int         m_cnt = 0;
   int         m_limit = 0;
   bit [7:0]   m_lfsr = 8'hA5;
   bit [7:0]   m_old;

   function automatic bit [7:0] lfsr_step(input bit [7:0] s);
      int taps[4] = '{8, 6, 5, 4};
      bit fb = 1'b0;
      foreach (taps[i]) fb ^= s[taps[i]-1];
      return {s[6:0], fb};
   endfunction

   function automatic bit wants(input bit [7:0] s, input int r);
      return (r == 7) || (int'(s % 8) <= r);
   endfunction

   always begin
      @(posedge clk);
      if (reset) begin
         m_mode = M_IDLE; m_srdy = 1'b0; m_seq = 0; m_cnt = 0; m_limit = 0;
         m_lfsr = 8'hA5; m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_mode != M_RUN) begin
            if (start) begin
               m_mode = M_RUN; m_limit = int'(num_xfers); m_cnt = 0;
               m_srdy = wants(m_lfsr, int'(rate));
            end
         end else begin
            m_fire = m_srdy && sif.p_drdy;
            m_old  = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            if (m_fire) begin
               m_seq = (m_seq + 1) % 128;
               if (m_cnt < 65535) m_cnt++;
               if (m_limit != 0 && m_cnt == m_limit) begin
                  m_mode = M_DONE; m_srdy = 1'b0;
               end else begin
                  m_srdy = wants(m_old, int'(rate));
               end
            end else if (!m_srdy) begin
               m_srdy = wants(m_old, int'(rate));
            end
         end
      end
      #1;
      if (m_valid) begin
         check("m_srdy", sif.p_srdy, m_srdy);
         check("m_data", sif.p_data, 32'h80 | m_seq);
         check("m_busy", busy, m_mode == M_RUN);
         check("m_done", done, m_mode == M_DONE);
         check("m_xfer_cnt", xfer_cnt, m_cnt);
      end
   end

   // One cycle of stimulus; logs the word that will transfer at the coming edge.
   task automatic cyc(input bit d, input bit s);
      @(negedge clk);
      sif.p_drdy = d;
      start = s;
      if (!reset && sif.p_srdy && d) words.push_back(sif.p_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; sif.p_drdy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      g = 0;
      words.delete();
   endtask

   task automatic run(input logic [2:0] r, input logic [15:0] n, input int pct,
                      input int budget, output int used);
      int k = 0;
      words.delete();
      rate = r; num_xfers = n;
      cyc(1'b0, 1'b1);
      @(posedge clk); #1;
      check("cnt_restart", xfer_cnt, 0);
      check("busy_start", busy, 1);
      check("done_clear", done, 0);
      if (r == 3'd7) check("srdy_latency", sif.p_srdy, 1);
      while (!done && k < budget) begin
         cyc($urandom_range(0, 99) < pct, 1'b0);
         k++;
      end
      used = k;
      check("done_reached", done, 1);
      check("final_cnt", xfer_cnt, n);
      check("nwords", words.size(), n);
      foreach (words[i]) check("word", words[i], 32'h80 | ((g + i) % 128));
      g = (g + int'(n)) % 128;
      check("end_data", sif.p_data, 32'h80 | g);
      check("end_srdy", sif.p_srdy, 0);
   endtask

   typedef struct {
      logic [2:0]  rate;
      logic [15:0] num;
      int          pct;
      logic [15:0] exp_cnt;
   } vec_t;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int used;
      int k;
      vecs[0] = '{3'd7, 16'd4,  100, 16'd4};
      vecs[1] = '{3'd0, 16'd20, 100, 16'd20};
      vecs[2] = '{3'd3, 16'd15, 60,  16'd15};
      vecs[3] = '{3'd5, 16'd1,  50,  16'd1};
      vecs[4] = '{3'd7, 16'd10, 30,  16'd10};
      vecs[5] = '{3'd1, 16'd8,  80,  16'd8};

      sif.p_drdy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_srdy", sif.p_srdy, 0);
      check("rst_data", sif.p_data, 8'h80);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", xfer_cnt, 0);
      reset = 1'b0;
      g = 0;

      // Table runs; after the first, each start is taken from DONE (continuation).
      foreach (vecs[i]) begin
         run(vecs[i].rate, vecs[i].num, vecs[i].pct, 3000, used);
         check("tbl_cnt", xfer_cnt, vecs[i].exp_cnt);
         if (vecs[i].rate == 3'd7 && vecs[i].pct == 100) check("tbl_cycles", used, vecs[i].num + 1);
         if (vecs[i].rate == 3'd0) check("tbl_bubbles", used > int'(vecs[i].num) + 1, 1);
      end

      // Backpressure: first offer held stable while drdy stays low.
      do_reset();
      rate = 3'd7; num_xfers = 16'd3;
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0);
         check("bp_srdy", sif.p_srdy, 1);
         check("bp_data", sif.p_data, 8'h80);
      end
      k = 0;
      while (!done && k < 50) begin cyc(1'b1, 1'b0); k++; end
      check("bp_nwords", words.size(), 3);
      foreach (words[i]) check("bp_word", words[i], 8'h80 + i);
      g = 3;

      // Continuation from DONE then randomized runs.
      run(3'd7, 16'd3, 100, 100, used);
      for (int i = 0; i < 8; i++)
         run(3'($urandom_range(0, 7)), 16'($urandom_range(1, 25)),
             int'($urandom_range(20, 100)), 3000, used);

      // Wrap through 0xFF back to 0x80.
      do_reset();
      run(3'd7, 16'd130, 100, 400, used);
      check("wrap_cycles", used, 131);

      // Unlimited random run.
      do_reset();
      rate = 3'($urandom_range(2, 7)); num_xfers = 16'd0;
      cyc(1'b0, 1'b1);
      repeat (60) cyc($urandom_range(0, 99) < 70, 1'b0);
      cyc(1'b0, 1'b0);
      check("unl_busy", busy, 1);
      check("unl_done", done, 0);
      check("unl_cnt", xfer_cnt, words.size());
      foreach (words[i]) check("unl_word", words[i], 32'h80 | (i % 128));

      // Reset mid-run with an offer pending.
      do_reset();
      rate = 3'd7; num_xfers = 16'd0;
      cyc(1'b0, 1'b1);
      k = 0;
      while (words.size() < 10 && k < 100) begin cyc(1'b1, 1'b0); k++; end
      cyc(1'b0, 1'b0);
      @(negedge clk);
      check("pre_rst_srdy", sif.p_srdy, 1);
      check("pre_rst_cnt", xfer_cnt, 10);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_srdy", sif.p_srdy, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", sif.p_data, 8'h80);
      @(negedge clk);
      reset = 1'b0;
      g = 0;
      run(3'd7, 16'd2, 100, 100, used);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sd_seq_gen.md
Name: sd_seq_gen

Overview:
- Srdy/drdy traffic producer that emits an incrementing data sequence for sd_seq_check-style consumers.
- Each word is {tag_val, seq}; seq increments once per accepted transfer.
- Sits directly upstream of the block under test and drives its consumer-side interface.
- Offer rate is throttled by an internal LFSR so downstream stall/bubble paths are exercised; run length is programmable.

Parameters:
- width, 8, total data width.
- tag_sz, 1, upper tag field width; count_sz = width - tag_sz, must be >= 1.
- tag_val, 0, constant placed in the tag field of every word.
- lfsr_seed, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- num_xfers  input  16  run length latched at start; 0 = unlimited.
- rate  input  3  offer throttle: 7 = offer every cycle; lower values = sparser offers.
- p_srdy  output  1  producer data valid.
- p_drdy  input  1  consumer ready.
- p_data  output  width  {tag_val, seq}.
- busy  output  1  high in RUN.
- done  output  1  high in DONE until the next start or reset.
- xfer_cnt  output  16  transfers completed in the current run.

Behaviour:
- All outputs are registered.
- Reset values: p_srdy=0, p_data={tag_val, 0}, busy=0, done=0, xfer_cnt=0, seq=0, lfsr=lfsr_seed, state=IDLE.
- Reset mid-run aborts at the same edge; any pending offer is dropped.
- Transfer: occurs at a posedge where p_srdy & p_drdy.
- Hold rule: once p_srdy=1, p_srdy and p_data stay constant until a transfer. p_srdy never drops without a transfer.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in RUN, frozen otherwise.
- Offer decision (off = lfsr[2:0] > rate):
  - Made in RUN whenever p_srdy=0, or at a transfer edge.
  - Next p_srdy = 1 when rate==7 or lfsr[2:0] <= rate, else 0.
- States and transitions:
  - IDLE: p_srdy=0. start -> RUN; latch num_xfers; xfer_cnt=0; p_srdy is loaded from the offer decision at the same edge.
  - RUN: on each transfer, seq <= seq+1 (wraps mod 2^count_sz with no flag) and xfer_cnt <= xfer_cnt+1.
  - RUN exit: if the latched limit is nonzero and xfer_cnt+1 == limit, go to DONE and drive p_srdy=0 next cycle. Otherwise reload p_srdy from the offer decision.
  - RUN ignores start.
  - DONE: done=1, p_srdy=0. start -> RUN (same actions as from IDLE); done clears.
  - seq is NOT reset by start, so back-to-back runs form one continuous sequence.
- Latency:
  - start to first p_srdy is 1 cycle when rate=7.
  - rate=7 with p_drdy held high gives one transfer per cycle.
- xfer_cnt saturates at 16'hFFFF in unlimited mode.
- xfer_cnt holds its final value in DONE.
- Wrap: with count_sz=7, the word after 0x7F is {tag_val, 0x00}.

Decomposition:
- Shared include file holds:
  - state encodings IDLE/RUN/DONE (2 bits);
  - LFSR tap mask constant;
  - count_sz derivation macro.
- One sub-module: sd_lfsr8 (seed parameter, enable input, 8-bit state output).
  - Reusable by other traffic generators in env/.

Test Plan:
- Basic run: reset, rate=7, p_drdy=1, num_xfers=4, start -> p_data 0x00,0x01,0x02,0x03 on 4 consecutive cycles; done=1 next cycle; xfer_cnt=4; p_srdy=0.
- Backpressure: rate=7, p_drdy low for 5 cycles after first offer -> p_srdy and p_data=0x00 held stable all 5 cycles; 0x00 transfers on the first cycle p_drdy=1.
- Throttle: rate=0, num_xfers=20, p_drdy=1 -> exactly 20 transfers, data 0x00..0x13 in order; bubbles observed; done asserted; paired sd_seq_check reports 0 errors.
- Wrap and tag: tag_sz=1, tag_val=1, width=8, num_xfers=130 -> words 0x80..0xFF then 0x80,0x81; no gap or duplicate.
- Continuation: two runs of num_xfers=3 with start in DONE -> second run emits 0x03,0x04,0x05; xfer_cnt restarts at 0.
- Reset mid-run: num_xfers=0, assert reset after 10 transfers while p_srdy=1, p_drdy=0 -> next cycle p_srdy=0, busy=0, seq=0; the next start emits 0x00.
